// File: rtl/bus_cmd_bridge.sv
// Byte-command bridge: rx opcodes load address/data nibbles, launch single bus
// reads/writes, and return response bytes through the tx handshake.
module bus_cmd_bridge #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        opcode,
    input  logic              en,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] bus_Addr,
    input  logic [DATA_W-1:0] bus_RData,
    output logic [DATA_W-1:0] bus_WData,
    output logic              Cmd,
    output logic              RW,
    input  logic              Finish,
    output logic              busy
);
    localparam int unsigned SNAP_W   = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned BCNT_W   = 4;
    localparam int unsigned DATA_NIB = DATA_W / 4;
    localparam int unsigned ADDR_NIB = ADDR_W / 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SNAP_W-1:0]  snap_q, snap_d, snap_ld;
    logic [BCNT_W-1:0]  left_q, left_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         resp_q, resp_d;
    logic               inc_q, inc_d;
    logic [7:0]         tx_data_d;
    logic               tx_en_d, cmd_d, rw_d, busy_d;

    assign bus_Addr  = addr_q;
    assign bus_WData = data_q;

    // Next-state and next-register values
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        snap_d    = snap_q;
        snap_ld   = '0;
        left_d    = left_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        inc_d     = inc_q;
        tx_data_d = tx_data;
        tx_en_d   = 1'b0;
        cmd_d     = 1'b0;
        rw_d      = RW;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    resp_d = opcode;
                    left_d = '0;
                    case (opcode[7:4])
                        4'hD: begin
                            data_d  = DATA_W'({data_q, opcode[3:0]});
                            state_d = ST_SEND;
                        end
                        4'hE: begin
                            addr_d  = ADDR_W'({addr_q, opcode[3:0]});
                            state_d = ST_SEND;
                        end
                        4'hC: begin
                            case (opcode[3:0])
                                4'h0: begin
                                    snap_ld = SNAP_W'(data_q) << (SNAP_W - DATA_W);
                                    left_d  = BCNT_W'(DATA_NIB - 1);
                                    state_d = ST_SEND;
                                end
                                4'h1: begin
                                    snap_ld = SNAP_W'(addr_q) << (SNAP_W - ADDR_W);
                                    left_d  = BCNT_W'(ADDR_NIB - 1);
                                    state_d = ST_SEND;
                                end
                                4'h2, 4'h3, 4'h4, 4'h5: begin
                                    cmd_d   = 1'b1;
                                    rw_d    = opcode[0];
                                    inc_d   = opcode[2];
                                    cnt_d   = '0;
                                    state_d = ST_BUS;
                                end
                                default: ;
                            endcase
                            // Readbacks send the top nibble first from a left-aligned snapshot
                            if (opcode[3:1] == 3'b000) begin
                                resp_d = {4'hC, snap_ld[SNAP_W-1 -: 4]};
                                snap_d = snap_ld << 4;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (Finish) begin
                    if (!RW) begin
                        data_d = bus_RData;
                    end
                    if (inc_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    rw_d    = 1'b0;
                    state_d = ST_SEND;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    resp_d  = 8'hCF;
                    rw_d    = 1'b0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (!tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = resp_q;
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (left_q != '0) begin
                    resp_d  = {4'hC, snap_q[SNAP_W-1 -: 4]};
                    snap_d  = snap_q << 4;
                    left_d  = left_q - BCNT_W'(1);
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            snap_q  <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            inc_q   <= 1'b0;
            tx_data <= '0;
            tx_en   <= 1'b0;
            Cmd     <= 1'b0;
            RW      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            snap_q  <= snap_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            inc_q   <= inc_d;
            tx_data <= tx_data_d;
            tx_en   <= tx_en_d;
            Cmd     <= cmd_d;
            RW      <= rw_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_cmd_bridge.sv
// Randomized bench for bus_cmd_bridge: a register/response model in plain
// arithmetic predicts every response byte and the resulting register values.
module tb_bus_cmd_bridge;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 10;
    localparam int DMASK = (1 << DATA_W) - 1;
    localparam int AMASK = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        opcode;
    logic              en;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_busy;
    logic [ADDR_W-1:0] bus_Addr;
    logic [DATA_W-1:0] bus_RData;
    logic [DATA_W-1:0] bus_WData;
    logic              Cmd;
    logic              RW;
    logic              Finish;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic busy_at_edge = 1'b0;
    logic xmit_busy = 1'b0;
    logic hold_busy = 1'b0;
    int xmit_len = 1;
    int xmit_left = 0;
    int bad_tx = 0;
    int cmd_hi = 0;
    logic [7:0] rx_q[$];
    int rx_cyc[$];
    logic [7:0] exp_q[$];
    int m_data = 0;
    int m_addr = 0;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic cmd_rw;

    assign tx_busy = xmit_busy | hold_busy;
    always #5 clk = ~clk;

    bus_cmd_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .en(en),
        .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
        .bus_Addr(bus_Addr), .bus_RData(bus_RData), .bus_WData(bus_WData),
        .Cmd(Cmd), .RW(RW), .Finish(Finish), .busy(busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        busy_at_edge <= tx_busy;
    end

    // Transmitter stand-in: captures sent bytes and raises busy for xmit_len cycles
    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            if (busy_at_edge !== 1'b0) bad_tx++;
            rx_q.push_back(tx_data);
            rx_cyc.push_back(cyc);
            xmit_left = xmit_len;
        end
        if (Cmd === 1'b1) cmd_hi++;
        if (xmit_left > 0) begin
            xmit_busy = 1'b1;
            xmit_left--;
        end else begin
            xmit_busy = 1'b0;
        end
    end

    // Reference model: register effects and expected response bytes of one command
    function automatic void model(input logic [7:0] op, input bit fin, input int rdata);
        int lo = int'(op[3:0]);
        case (op[7:4])
            4'hD: begin
                m_data = ((m_data << 4) | lo) & DMASK;
                exp_q.push_back(op);
            end
            4'hE: begin
                m_addr = ((m_addr << 4) | lo) & AMASK;
                exp_q.push_back(op);
            end
            4'hC: begin
                if (lo == 0) begin
                    for (int i = int'(DATA_W / 4) - 1; i >= 0; i--)
                        exp_q.push_back(8'hC0 | 8'((m_data >> (4 * i)) & 15));
                end else if (lo == 1) begin
                    for (int i = int'(ADDR_W / 4) - 1; i >= 0; i--)
                        exp_q.push_back(8'hC0 | 8'((m_addr >> (4 * i)) & 15));
                end else if (lo >= 2 && lo <= 5) begin
                    if (fin) begin
                        if (lo == 2 || lo == 4) m_data = rdata & DMASK;
                        if (lo >= 4) m_addr = (m_addr + 1) & AMASK;
                        exp_q.push_back(op);
                    end else begin
                        exp_q.push_back(8'hCF);
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic send_op(input logic [7:0] op, output int at);
        @(posedge clk); #1;
        opcode = op;
        en = 1'b1;
        at = cyc;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    // Issue one command; for bus ops assert Finish during BUS cycle k (k=0: never)
    task automatic issue(input logic [7:0] op, input int k, input int rdata,
                         output int en_at, output int cmd_at, output int fin_at);
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
        cmd_at = -1;
        fin_at = -1;
        send_op(op, en_at);
        if (op >= 8'hC2 && op <= 8'hC5) begin
            for (int n = 0; n < 4 && Cmd !== 1'b1; n++) begin
                @(posedge clk); #1;
            end
            if (Cmd === 1'b1) begin
                cmd_at = cyc;
                cmd_addr = bus_Addr;
                cmd_wdata = bus_WData;
                cmd_rw = RW;
                if (k > 0) begin
                    repeat (k - 1) begin
                        @(posedge clk); #1;
                    end
                    Finish = 1'b1;
                    bus_RData = DATA_W'(rdata);
                    fin_at = cyc;
                    @(posedge clk); #1;
                    Finish = 1'b0;
                end
            end
        end
    endtask

    task automatic collect(input int n, output bit timed_out);
        int w = 0;
        while (rx_q.size() < n && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        timed_out = (rx_q.size() < n);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] op, input int k, input int rdata,
                       output int en_at, output int cmd_at, output int fin_at, output bit to);
        issue(op, k, rdata, en_at, cmd_at, fin_at);
        model(op, (k >= 1 && k <= int'(TIMEOUT)), rdata);
        collect(exp_q.size(), to);
    endtask

    task automatic test_reset;
        checks++;
        if ({tx_data, tx_en, Cmd, RW, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl got tx_data=%h tx_en=%b Cmd=%b RW=%b busy=%b want all 0",
                     tx_data, tx_en, Cmd, RW, busy);
        end
        checks++;
        if (bus_Addr !== '0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0", bus_Addr);
        end
        checks++;
        if (bus_WData !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", bus_WData);
        end
    endtask

    task automatic test_shift_readback;
        int e, c, f;
        bit to;
        logic [7:0] ops[2] = '{8'hD1, 8'hD2};
        foreach (ops[j]) begin
            run(ops[j], 0, 0, e, c, f, to);
            checks++;
            if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL echo_data n=%0d got %h want %h", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00, exp_q[0]);
            end
            checks++;
            if (rx_cyc.size() == 0 || rx_cyc[0] - e != 2) begin
                errors++;
                $display("FAIL echo_latency got %0d want 2", rx_cyc.size() ? rx_cyc[0] - e : -1);
            end
        end
        run(8'hC0, 0, 0, e, c, f, to);
        checks++;
        if (to || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rb_data_count got %0d want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rb_data_byte%0d got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus_WData !== DATA_W'(m_data) || busy !== 1'b0) begin
            errors++;
            $display("FAIL rb_data_state got data=%h busy=%b want data=%h busy=0", bus_WData, busy, m_data);
        end
    endtask

    task automatic test_write;
        int e, c, f, c0, a_exp, d_exp;
        bit to;
        for (int i = 1; i <= 4; i++) begin
            run(8'hE0 | 8'(i), 0, 0, e, c, f, to);
            checks++;
            if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL echo_addr%0d n=%0d want %h", i, rx_q.size(), exp_q[0]);
            end
        end
        a_exp = m_addr;
        d_exp = m_data;
        c0 = cmd_hi;
        run(8'hC3, 5, 0, e, c, f, to);
        checks++;
        if (c < 0 || cmd_addr !== ADDR_W'(a_exp) || cmd_rw !== 1'b1 || cmd_wdata !== DATA_W'(d_exp)) begin
            errors++;
            $display("FAIL wr_cmd got seen=%0d addr=%h rw=%b wdata=%h want addr=%h rw=1 wdata=%h",
                     c, cmd_addr, cmd_rw, cmd_wdata, a_exp, d_exp);
        end
        checks++;
        if (cmd_hi - c0 != 1) begin
            errors++;
            $display("FAIL wr_cmd_width got %0d cycles want 1", cmd_hi - c0);
        end
        checks++;
        if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL wr_resp n=%0d got %h want %h", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00, exp_q[0]);
        end
        checks++;
        if (rx_cyc.size() == 0 || f < 0 || rx_cyc[0] - f != 2) begin
            errors++;
            $display("FAIL wr_latency got %0d want 2", rx_cyc.size() ? rx_cyc[0] - f : -1);
        end
        checks++;
        if (RW !== 1'b0 || bus_Addr !== ADDR_W'(m_addr)) begin
            errors++;
            $display("FAIL wr_after got RW=%b addr=%h want RW=0 addr=%h", RW, bus_Addr, m_addr);
        end
    endtask

    task automatic test_read_wrap;
        int e, c, f;
        bit to;
        for (int i = 0; i < 4; i++) run(8'hEF, 0, 0, e, c, f, to);
        run(8'hC4, 3, 'hA5, e, c, f, to);
        checks++;
        if (cmd_rw !== 1'b0 || cmd_addr !== ADDR_W'(AMASK)) begin
            errors++;
            $display("FAIL rd_cmd got rw=%b addr=%h want rw=0 addr=%h", cmd_rw, cmd_addr, AMASK);
        end
        checks++;
        if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL rd_resp n=%0d want %h", rx_q.size(), exp_q[0]);
        end
        checks++;
        if (bus_Addr !== ADDR_W'(m_addr) || bus_WData !== DATA_W'(m_data)) begin
            errors++;
            $display("FAIL rd_wrap got addr=%h data=%h want addr=%h data=%h", bus_Addr, bus_WData, m_addr, m_data);
        end
        for (int r = 0; r < 2; r++) begin
            run(r == 0 ? 8'hC0 : 8'hC1, 0, 0, e, c, f, to);
            checks++;
            if (to || rx_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rb%0d_count got %0d want %0d", r, rx_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rb%0d_byte%0d got %h want %h", r, i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int e, c, f, pre_d, pre_a;
        bit to;
        pre_d = m_data;
        pre_a = m_addr;
        run(8'hC2, 0, 0, e, c, f, to);
        checks++;
        if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL to_resp n=%0d want %h", rx_q.size(), exp_q[0]);
        end
        checks++;
        if (rx_cyc.size() == 0 || c < 0 || rx_cyc[0] - c != int'(TIMEOUT) + 1) begin
            errors++;
            $display("FAIL to_latency got %0d want %0d", rx_cyc.size() ? rx_cyc[0] - c : -1, TIMEOUT + 1);
        end
        checks++;
        if (bus_WData !== DATA_W'(pre_d) || bus_Addr !== ADDR_W'(pre_a) || RW !== 1'b0) begin
            errors++;
            $display("FAIL to_state got data=%h addr=%h RW=%b want %h %h 0", bus_WData, bus_Addr, RW, pre_d, pre_a);
        end
        rx_q.delete();
        Finish = 1'b1;
        bus_RData = ~DATA_W'(pre_d);
        @(posedge clk); #1;
        Finish = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() != 0 || busy !== 1'b0 || bus_WData !== DATA_W'(pre_d)) begin
            errors++;
            $display("FAIL late_finish got n=%0d busy=%b data=%h want 0 0 %h", rx_q.size(), busy, bus_WData, pre_d);
        end
        run(8'hC4, TIMEOUT, 'h3C, e, c, f, to);
        checks++;
        if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0] || bus_Addr !== ADDR_W'(m_addr)) begin
            errors++;
            $display("FAIL finish_at_limit got n=%0d addr=%h want %h addr=%h", rx_q.size(), bus_Addr, exp_q[0], m_addr);
        end
        run(8'hC5, TIMEOUT + 1, 'h77, e, c, f, to);
        checks++;
        if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0] || bus_Addr !== ADDR_W'(m_addr)) begin
            errors++;
            $display("FAIL finish_past_limit got n=%0d addr=%h want %h addr=%h", rx_q.size(), bus_Addr, exp_q[0], m_addr);
        end
    endtask

    task automatic test_busy_hold;
        int e, c, f, rel, n_before, b0;
        bit to;
        b0 = bad_tx;
        xmit_len = 3;
        hold_busy = 1'b1;
        issue(8'hC0, 0, 0, e, c, f);
        model(8'hC0, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i % 4 == 1) begin
                opcode = 8'hD0 | 8'($urandom_range(0, 15));
                en = 1'b1;
            end else begin
                en = 1'b0;
            end
        end
        en = 1'b0;
        n_before = rx_q.size();
        hold_busy = 1'b0;
        rel = cyc;
        collect(exp_q.size(), to);
        checks++;
        if (n_before != 0) begin
            errors++;
            $display("FAIL hold_no_tx got %0d bytes want 0", n_before);
        end
        checks++;
        if (to || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL hold_count got %0d want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL hold_byte%0d got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < rx_cyc.size(); i++) begin
            checks++;
            if (rx_cyc[i] - rx_cyc[i-1] < 2) begin
                errors++;
                $display("FAIL hold_spacing%0d got %0d want >=2", i, rx_cyc[i] - rx_cyc[i-1]);
            end
        end
        checks++;
        if (bad_tx != b0 || rx_cyc.size() == 0 || rx_cyc[0] <= rel) begin
            errors++;
            $display("FAIL hold_tx_while_busy got %0d want 0", bad_tx - b0);
        end
        checks++;
        if (bus_WData !== DATA_W'(m_data) || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignored_en got data=%h busy=%b want %h 0", bus_WData, busy, m_data);
        end
        xmit_len = 1;
    endtask

    task automatic test_random;
        for (int it = 0; it < 60; it++) begin
            int r = int'($urandom_range(0, 9));
            int k = 0;
            int rd = int'($urandom_range(0, DMASK));
            int e, c, f, c0, want_cmd;
            bit to;
            logic [7:0] op;
            xmit_len = int'($urandom_range(0, 3));
            case (r)
                0, 1, 2: op = 8'hD0 | 8'($urandom_range(0, 15));
                3, 4:    op = 8'hE0 | 8'($urandom_range(0, 15));
                5:       op = 8'hC0;
                6:       op = 8'hC1;
                7, 8: begin
                    op = 8'hC2 + 8'($urandom_range(0, 3));
                    k = int'($urandom_range(1, TIMEOUT + 2));
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0:       op = 8'($urandom_range(0, 191));
                        1:       op = 8'hC6 + 8'($urandom_range(0, 9));
                        default: op = 8'hF0 | 8'($urandom_range(0, 15));
                    endcase
                end
            endcase
            want_cmd = (op >= 8'hC2 && op <= 8'hC5) ? 1 : 0;
            c0 = cmd_hi;
            run(op, k, rd, e, c, f, to);
            checks++;
            if (to || rx_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count op=%h got %0d want %0d", it, op, rx_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d op=%h got %h want %h", it, i, op, rx_q[i], exp_q[i]);
                end
            end
            checks++;
            if (busy !== 1'b0 || bus_Addr !== ADDR_W'(m_addr) || bus_WData !== DATA_W'(m_data)) begin
                errors++;
                $display("FAIL rand%0d_state op=%h got busy=%b addr=%h data=%h want 0 %h %h",
                         it, op, busy, bus_Addr, bus_WData, m_addr, m_data);
            end
            checks++;
            if (cmd_hi - c0 != want_cmd) begin
                errors++;
                $display("FAIL rand%0d_cmd op=%h got %0d want %0d", it, op, cmd_hi - c0, want_cmd);
            end
        end
        xmit_len = 1;
    endtask

    task automatic test_reset_mid_bus;
        int e, c, f;
        bit to;
        issue(8'hC3, 0, 0, e, c, f);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        m_data = 0;
        m_addr = 0;
        checks++;
        if ({tx_data, tx_en, Cmd, RW, busy} !== 12'h000 || bus_Addr !== '0 || bus_WData !== '0) begin
            errors++;
            $display("FAIL mid_reset got tx_data=%h tx_en=%b Cmd=%b RW=%b busy=%b addr=%h data=%h want all 0",
                     tx_data, tx_en, Cmd, RW, busy, bus_Addr, bus_WData);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet got n=%0d busy=%b want 0 0", rx_q.size(), busy);
        end
        run(8'hD7, 0, 0, e, c, f, to);
        checks++;
        if (to || rx_q.size() != 1 || rx_q[0] !== exp_q[0] || bus_WData !== DATA_W'(m_data)) begin
            errors++;
            $display("FAIL post_reset_cmd got n=%0d data=%h want %h data=%h", rx_q.size(), bus_WData, exp_q[0], m_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        opcode = 8'h00;
        Finish = 1'b0;
        bus_RData = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_shift_readback;
        test_write;
        test_read_wrap;
        test_timeout;
        test_busy_hold;
        test_random;
        test_reset_mid_bus;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_cmd_bridge.md
Name: bus_cmd_bridge

Overview:
- Byte-command bridge between the UART link (rx opcode strobe in, tx byte out) and the internal system bus.
- Address and data registers are parametrised and loaded a nibble at a time by shift opcodes.
- Read and write are single bus transactions, with optional post-increment of the address and a bus timeout.
- Each accepted command returns one or more response bytes through the tx handshake.

Parameters:
- DATA_W, 8, bus data width; multiple of 4, 4..32.
- ADDR_W, 16, bus address width; multiple of 4, 4..32.
- TIMEOUT, 255, max cycles waiting for Finish before abort; 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  8  command byte from rx.
- en  in  1  one-cycle strobe, opcode valid.
- tx_data  out  8  response byte to transmitter.
- tx_en  out  1  one-cycle send strobe.
- tx_busy  in  1  transmitter busy; rises within 1 cycle after tx_en.
- bus_Addr  out  ADDR_W  bus address; equals address register.
- bus_RData  in  DATA_W  bus read data, valid with Finish.
- bus_WData  out  DATA_W  bus write data; equals data register.
- Cmd  out  1  one-cycle bus request pulse.
- RW  out  1  0 read, 1 write; held from Cmd until the transaction ends.
- Finish  in  1  bus completion strobe.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: tx_data 0, tx_en 0, Cmd 0, RW 0, busy 0, address register 0, data register 0, state IDLE. Reset mid-transaction aborts it and sends no response.
- en outside IDLE: ignored, with no queueing.
- Opcodes accepted in IDLE; the response is built and the state goes to SEND unless noted:
  - 1101_nnnn: data <= {data[DATA_W-5:0], nnnn}. Response = opcode echo.
  - 1110_nnnn: addr <= {addr[ADDR_W-5:0], nnnn}. Response = opcode echo.
  - 1100_0010: read. 1100_0100: read with address post-increment. Go to BUS with RW=0 and Cmd=1 for exactly one cycle.
  - 1100_0011: write. 1100_0101: write with address post-increment. Go to BUS with RW=1 and Cmd=1 for exactly one cycle.
  - 1100_0000: read back the data register as DATA_W/4 bytes 1100_nnnn, most significant nibble first.
  - 1100_0001: read back the address register the same way, ADDR_W/4 bytes.
  - Any other opcode: ignored, no response, stay in IDLE.
- BUS state:
  - A counter clears on entry and increments each cycle.
  - Finish=1: on a read, data <= bus_RData. If post-increment, addr <= addr+1, wrapping modulo 2^ADDR_W. Response = opcode echo.
  - Counter reaches TIMEOUT without Finish: response = 0xCF. Data and addr are unchanged. RW returns to 0.
  - Finish in the same cycle as timeout: Finish wins.
  - Finish while not in BUS: ignored.
- SEND state: wait for tx_busy=0, then drive tx_data and tx_en=1 for one cycle, then go to GAP.
- GAP state:
  - tx_en=0 for one cycle.
  - If response bytes remain, shift the next nibble, go to SEND, and decrement the byte counter.
  - Otherwise go to IDLE.
- Latency, tx_busy low throughout:
  - Shift or echo opcode: tx_en pulses 2 cycles after en.
  - Bus op: tx_en pulses 2 cycles after Finish.
- Back-to-back bytes: spacing is governed by tx_busy, minimum 2 cycles apart.
- Multi-byte readbacks snapshot the register at command acceptance.

Test Plan:
- Reset default widths, send D1,D2,C0 -> echoes D1,D2 then bytes C1,C2; data=0x12; busy low afterward.
- ADDR_W=16: send E1,E2,E3,E4,C3 -> Cmd pulse one cycle, bus_Addr=0x1234, RW=1; Finish after 5 cycles -> response C3.
- Addr=0xFFFF, send C4, Finish with bus_RData=0xA5 -> data=0xA5, addr=0x0000, response C4; then C0 returns CA,C5.
- TIMEOUT=10, send C2, never assert Finish -> response CF after 10 cycles; data and addr unchanged; Finish arriving later is ignored.
- DATA_W=16, tx_busy held high 20 cycles during readback -> exactly 4 tx_en pulses, each only while tx_busy=0; en strobes sent meanwhile are ignored.
- Assert rst_n low while in BUS -> all outputs at reset values immediately; no tx_en pulse after release.
